// File: rtl/pcileech_led_ctl.sv
// pcileech_led_ctl: N-channel status LED controller with a shared ms timebase
// and per-channel mode select (off/on/level/activity/blink/act-blink/heartbeat).
module pcileech_led_ctl #(
   parameter int          NUM_LEDS      = 6,
   parameter int          CLK_HZ        = 100000000,
   parameter int          STRETCH_MS    = 50,
   parameter int          BLINK_HALF_MS = 250,
   parameter int          HB_ON_MS      = 40,
   parameter logic [31:0] INVERT        = 32'h0
)(
   input  logic                  clk,
   input  logic                  rst,
   input  logic [3*NUM_LEDS-1:0] cfg_mode,
   input  logic [NUM_LEDS-1:0]   evt,
   input  logic [NUM_LEDS-1:0]   lvl,
   output logic [NUM_LEDS-1:0]   led,
   output logic                  tick_ms
);
   localparam int TPM = CLK_HZ / 1000;
   localparam int PW  = $clog2(TPM);
   localparam int PHN = 2 * BLINK_HALF_MS;
   localparam int PHW = $clog2(PHN);
   localparam int SW  = $clog2(STRETCH_MS + 1);
   logic [PW-1:0]       r_pre;
   logic [PHW-1:0]      r_ph;
   logic [SW-1:0]       r_scnt [NUM_LEDS];
   logic [NUM_LEDS-1:0] w_act;
   logic [NUM_LEDS-1:0] w_raw;
   logic                w_blink;
   logic                w_hb;
   assign w_blink = r_ph < PHW'(BLINK_HALF_MS);
   assign w_hb    = r_ph < PHW'(HB_ON_MS);
   always_ff @(posedge clk) begin
      if (rst) begin
         r_pre   <= '0;
         r_ph    <= '0;
         tick_ms <= 1'b0;
      end else begin
         r_pre   <= (r_pre == PW'(TPM - 1)) ? '0 : r_pre + 1'b1;
         tick_ms <= r_pre == PW'(TPM - 1);
         if (tick_ms)
            r_ph <= (r_ph == PHW'(PHN - 1)) ? '0 : r_ph + 1'b1;
      end
   end
   // A fresh event reloads the full window even on a tick cycle; otherwise count down to zero.
   always_ff @(posedge clk) begin
      if (rst)
         r_scnt <= '{default: '0};
      else
         for (int i = 0; i < NUM_LEDS; i++)
            if (evt[i])
               r_scnt[i] <= SW'(STRETCH_MS);
            else if (tick_ms && r_scnt[i] != '0)
               r_scnt[i] <= r_scnt[i] - 1'b1;
   end
   always_comb begin
      w_act = '0;
      w_raw = '0;
      for (int i = 0; i < NUM_LEDS; i++) begin
         w_act[i] = evt[i] | (r_scnt[i] != '0);
         case (cfg_mode[3*i +: 3])
            3'd1:    w_raw[i] = 1'b1;
            3'd2:    w_raw[i] = lvl[i];
            3'd3:    w_raw[i] = w_act[i];
            3'd4:    w_raw[i] = w_blink;
            3'd5:    w_raw[i] = w_act[i] ? w_blink : 1'b1;
            3'd6:    w_raw[i] = w_hb;
            default: w_raw[i] = 1'b0;
         endcase
      end
   end
   always_ff @(posedge clk)
      led <= rst ? INVERT[NUM_LEDS-1:0] : w_raw ^ INVERT[NUM_LEDS-1:0];
endmodule

// File: doc/pcileech_led_ctl.md
Name: pcileech_led_ctl

Overview:
Parametrised N-channel status-LED controller for board top modules. It replaces the hard-wired per-LED drive used today with a common timebase and a per-channel mode select. Supported modes are off, on, level-follow, activity stretch, blink, activity-blink and heartbeat, with per-channel output polarity. Board tops route core status and activity signals into it and drive LED pins from its registered outputs.

Parameters:
NUM_LEDS, 6, number of LED channels (1..32).
CLK_HZ, 100000000, clk frequency in Hz; CLK_HZ/1000 must be >= 2.
STRETCH_MS, 50, activity stretch window in ms (>= 1).
BLINK_HALF_MS, 250, blink half-period in ms (>= 1); full period is 2*BLINK_HALF_MS.
HB_ON_MS, 40, heartbeat on-time per period in ms (1..2*BLINK_HALF_MS-1).
INVERT, 32'h0, bit i set = channel i active-low pin.

Ports:
clk  in  1  system clock, CLK_HZ; all logic on rising edge.
rst  in  1  synchronous reset, active-high.
cfg_mode  in  3*NUM_LEDS  mode of channel i at bits [3i+2:3i]; may change any cycle.
evt  in  NUM_LEDS  activity pulse per channel; each high cycle counts as one event.
lvl  in  NUM_LEDS  level input per channel.
led  out  NUM_LEDS  registered pin drive, polarity per INVERT.
tick_ms  out  1  registered 1-cycle pulse once per ms, shared timebase (debug/reuse).

Behaviour:
- Prescaler:
  - pre counts 0..CLK_HZ/1000-1 and wraps.
  - tick_ms is registered high exactly in the cycle after pre == CLK_HZ/1000-1, so period = CLK_HZ/1000 cycles.
- Phase counter:
  - ph counts 0..2*BLINK_HALF_MS-1, advances on tick_ms, wraps to 0.
  - blink = (ph < BLINK_HALF_MS).
  - hb = (ph < HB_ON_MS).
- Stretch counter per channel:
  - scnt[i] has width clog2(STRETCH_MS+1).
  - evt[i] loads scnt[i] = STRETCH_MS. This takes priority over a simultaneous tick_ms.
  - Otherwise tick_ms with scnt != 0 decrements it. It saturates at 0 and never wraps.
  - act[i] = evt[i] | (scnt[i] != 0).
  - scnt runs in every mode, so switching into an activity mode shows the remaining window.
- Modes (raw[i]):
  - 0 OFF: 0.
  - 1 ON: 1.
  - 2 LEVEL: lvl[i].
  - 3 ACTIVITY: act[i].
  - 4 BLINK: blink.
  - 5 ACT_BLINK: act[i] ? blink : 1. Solid when idle, blinking while busy.
  - 6 HEARTBEAT: hb.
  - 7 reserved: behaves as OFF.
- Output:
  - led[i] <= raw[i] ^ INVERT[i], registered.
  - Latency from cfg_mode/lvl/evt change to led = 1 cycle.
- Activity window after the last evt:
  - led stays asserted through the STRETCH_MS-th tick_ms after the last evt.
  - It deasserts the cycle after that tick.
  - Window length is in (STRETCH_MS-1, STRETCH_MS] ms plus 1 cycle, depending on prescaler phase.
- Retrigger: an evt during the window reloads scnt to the full STRETCH_MS. Back-to-back evt every cycle holds led asserted indefinitely.
- Reset:
  - pre = 0, ph = 0, scnt = 0, tick_ms = 0, led[i] = INVERT[i] (logical off).
  - Reset mid-window clears the stretch immediately: led is off on the cycle after rst.
  - evt asserted during rst is ignored.
  - The first tick_ms after rst deasserts comes CLK_HZ/1000 cycles later.
- All channels share pre/ph, so blinking channels are phase-aligned.

Test Plan:
- Sim params: CLK_HZ=10000 (10 cycles/ms), STRETCH_MS=3, BLINK_HALF_MS=4, HB_ON_MS=1, NUM_LEDS=4, INVERT=4'b1000.
- Reset/polarity: hold rst 5 cycles with evt=4'hF, all modes ACTIVITY -> led=4'b1000 during and after rst; tick_ms first high 10 cycles after rst release, then every 10 cycles.
- Level/static: modes {OFF, ON, LEVEL, LEVEL}, toggle lvl[2] at cycle N -> led[2] follows at N+1; led[0]=0, led[1]=1; led[3] inverted relative to lvl[3].
- Activity stretch and retrigger:
  - single evt[0] pulse -> led[0] high next cycle, low the cycle after the 3rd subsequent tick_ms.
  - second pulse 15 cycles after the first -> window extends to 3 ticks after the second pulse.
  - evt coincident with tick_ms -> scnt = 3, no decrement that cycle.
- Blink/heartbeat: mode BLINK -> led 40 cycles high / 40 low from ph=0; mode HEARTBEAT -> 10 cycles high per 80-cycle period, rising edges aligned with BLINK rising edges.
- ACT_BLINK and mode switch:
  - idle -> led solid 1; evt burst -> led follows blink for the window, then returns to 1.
  - switch OFF->ACTIVITY 1 ms after evt -> led high immediately for the remaining window.
  - mode 7 -> led 0.
- Reset mid-window: assert rst 1 cycle, 1 ms into a stretch -> led off on the cycle after rst, no residual window after deassert.
